mem_wait_bridge: RTL and testbench
==================================

# mem_wait_bridge

Wait-state bridge between the multicycle MIPS datapath's single memory port and an external memory with a request/acknowledge handshake. It decodes memory accesses from the controller outputs (`irwrite` for instruction fetch, `iord` for load/store data), runs one handshake per access, and asserts `stall` so the controller and datapath hold state until data returns. It sits directly downstream of the main controller, in parallel with the datapath's memory address mux.

## Interface
Parameters:
- `AW`, 32: address width (byte address, passed through unmodified).
- `DW`, 32: data width.
- `TIMEOUT`, 255: maximum cycles in REQ before an error is declared (only with `MEM_WAIT_BRIDGE_TIMEOUT_EN`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `irwrite`  in  1  controller output; instruction fetch access.
- `iord`  in  1  controller output; data access (load or store).
- `memwrite`  in  1  controller output; access is a store.
- `adr`  in  AW  memory address from the datapath mux.
- `wd`  in  DW  store data from the datapath.
- `stall`  out  1  holds the controller state register and all datapath enables.
- `rd`  out  DW  registered read data to the IR and data register.
- `mreq`  out  1  external request.
- `mwe`  out  1  external write enable, valid while `mreq`=1.
- `maddr`  out  AW  external address, valid while `mreq`=1.
- `mwdata`  out  DW  external write data, valid while `mreq`=1.
- `mack`  in  1  external acknowledge; completes the current request.
- `mrdata`  in  DW  external read data, valid with `mack`.
- `timeout_err`  out  1  sticky error flag.

## Operation
- `access = irwrite | iord`. `stall = access & (state != DONE)` is combinational from the inputs and state. `stall` is forced to 1 in ERR.
- States: IDLE, REQ, DONE, and ERR (ERR exists only with the macro).
- IDLE:
  - When `access`=1, capture `adr`, `wd` and `memwrite` into the `maddr`, `mwdata` and `mwe` registers.
  - Set the `mreq` register to 1 and go to REQ.
- REQ:
  - Hold `mreq`, `maddr`, `mwdata` and `mwe` stable.
  - On `mack`=1: clear `mreq`. On a read (`mwe`=0), also load `rd` from `mrdata`. Go to DONE.
  - A write acknowledge leaves `rd` unchanged.
- DONE: `stall`=0 for exactly one cycle so the controller advances and enables take effect. Go to IDLE unconditionally.
- `mack` outside REQ is ignored.
- If `access` drops during REQ, which a correctly stalled controller never does, the transaction still completes normally.
- Integration rule: the controller state register updates only when `stall`=0. The datapath gates `pcwrite`, `irwrite`, `regwrite`, `memwrite` and the branch enable with `~stall`.

## Timing
- Reset values: state=IDLE, `mreq`=0, `mwe`=0, `maddr`=0, `mwdata`=0, `rd`=0, `timeout_err`=0, timeout counter=0.
- `stall` follows inputs combinationally. Reset asserted mid-transaction immediately drops `mreq` and returns to IDLE.
- Latency from access presentation (cycle 0) to the `stall`=0 cycle:
  - Cycle 0: IDLE, `stall`=1.
  - Cycle 1: REQ, `mreq`=1.
  - On the `mack` cycle k ≥ 1: `rd` is valid from cycle k+1.
  - Cycle k+1: DONE, `stall`=0.
  - Minimum is 2 stall cycles, with `mack` in cycle 1.
- `mreq` is held high until the `mack` edge. Address, data and write enable do not change while `mreq`=1.
- A new access seen in IDLE in the cycle after DONE starts a new transaction, giving back-to-back fetch and data accesses.

## Configuration
- `MEM_WAIT_BRIDGE_TIMEOUT_EN` defined:
  - An 8..16-bit counter clears on entry to REQ and increments each REQ cycle without `mack`.
  - When the count reaches `TIMEOUT` without `mack`: go to ERR, clear `mreq`, set `timeout_err`=1.
  - ERR holds `stall`=1 and is left only by reset.
  - `mack` arriving in the same cycle the count reaches `TIMEOUT` wins: normal completion.
- Not defined: no counter and no ERR state. REQ waits indefinitely. `timeout_err` is tied to 0.

## Test plan
- Fetch read: `irwrite`=1, `adr`=0x00000004, `mack` in cycle 1 with `mrdata`=0x20080005 -> `mreq`=1 at cycle 1 with `mwe`=0 and `maddr`=0x4; `stall`=1 in cycles 0–1 and 0 in cycle 2; `rd`=0x20080005.
- Store with wait states: `iord`=1, `memwrite`=1, `adr`=0x54, `wd`=0x7, `mack` at cycle 4 -> `mwe`=1 and `mwdata`=0x7 stable in cycles 1–4; `stall`=0 at cycle 5; `rd` unchanged.
- Back-to-back: fetch completes, then a load is presented in the next IDLE cycle -> second `mreq` rises one cycle after IDLE; no acknowledge is lost or duplicated.
- Reset during REQ, cycle 2 -> `mreq`=0 and `stall`=0 asynchronously; state=IDLE; a subsequent access completes normally.
- With the macro and `TIMEOUT`=4, no `mack` -> ERR after 4 REQ cycles; `timeout_err`=1 and `stall`=1 until reset. Repeat with `mack` on the 4th cycle -> normal DONE, `timeout_err`=0.

Source files
------------

// File: rtl/mem_wait_bridge.sv
// Request/acknowledge wait-state bridge for the multicycle MIPS memory port.
// Optional REQ timeout with sticky error state: define MEM_WAIT_BRIDGE_TIMEOUT_EN.
module mem_wait_bridge #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          irwrite,
  input  logic          iord,
  input  logic          memwrite,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] wd,
  output logic          stall,
  output logic [DW-1:0] rd,
  output logic          mreq,
  output logic          mwe,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mwdata,
  input  logic          mack,
  input  logic [DW-1:0] mrdata,
  output logic          timeout_err
);

`ifdef MEM_WAIT_BRIDGE_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2, ERR = 2'd3} state_t;

  localparam int unsigned CW = 16;
  // Last REQ count before expiry: a miss at this count means TIMEOUT cycles elapsed.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t state;
  logic   access;

  assign access = irwrite | iord;

  always_comb begin
    stall = access & (state != DONE);
`ifdef MEM_WAIT_BRIDGE_TIMEOUT_EN
    if (state == ERR) stall = 1'b1;
`endif
  end

`ifndef MEM_WAIT_BRIDGE_TIMEOUT_EN
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mreq        <= 1'b0;
      mwe         <= 1'b0;
      maddr       <= '0;
      mwdata      <= '0;
      rd          <= '0;
`ifdef MEM_WAIT_BRIDGE_TIMEOUT_EN
      cnt         <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            maddr  <= adr;
            mwdata <= wd;
            mwe    <= memwrite;
            mreq   <= 1'b1;
            state  <= REQ;
`ifdef MEM_WAIT_BRIDGE_TIMEOUT_EN
            cnt    <= '0;
`endif
          end
        end
        REQ: begin
          // Acknowledge takes priority over an expiring count.
          if (mack) begin
            mreq  <= 1'b0;
            if (!mwe) rd <= mrdata;
            state <= DONE;
          end
`ifdef MEM_WAIT_BRIDGE_TIMEOUT_EN
          else if (cnt == CNT_LAST) begin
            cnt         <= cnt + 1'b1;
            mreq        <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE: state <= IDLE;
`ifdef MEM_WAIT_BRIDGE_TIMEOUT_EN
        ERR:  state <= ERR;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wait_bridge.sv
// Directed scoreboard bench for mem_wait_bridge; timeout cases build only
// when MEM_WAIT_BRIDGE_TIMEOUT_EN is defined.
module tb_mem_wait_bridge;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          reset;
  logic          irwrite, iord, memwrite;
  logic [AW-1:0] adr;
  logic [DW-1:0] wd;
  logic          stall;
  logic [DW-1:0] rd;
  logic          mreq, mwe;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwdata;
  logic          mack;
  logic [DW-1:0] mrdata;
  logic          timeout_err;

  mem_wait_bridge #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .irwrite(irwrite), .iord(iord), .memwrite(memwrite),
    .adr(adr), .wd(wd), .stall(stall), .rd(rd), .mreq(mreq), .mwe(mwe),
    .maddr(maddr), .mwdata(mwdata), .mack(mack), .mrdata(mrdata),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd;
  } txn_t;

  txn_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] model_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access: IDLE presentation cycle, ack_cyc REQ cycles (ack on the last), then DONE.
  task automatic access_txn(input logic fetch, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW-1:0] rdata,
                            input int unsigned ack_cyc);
    txn_t          t;
    logic [DW-1:0] prev_rd;
    prev_rd = model_rd;
    t.we    = we;
    t.addr  = a;
    t.wdata = d;
    t.rd    = we ? model_rd : rdata;
    sb.push_back(t);
    model_rd = t.rd;

    @(negedge clk);
    irwrite = fetch; iord = !fetch; memwrite = we; adr = a; wd = d; mack = 1'b0;
    #1;
    chk("idle_stall", stall, 1);
    chk("idle_mreq", mreq, 0);
    chk("idle_rd_hold", rd, prev_rd);

    for (int unsigned i = 1; i <= ack_cyc; i++) begin
      @(negedge clk);
      adr = ~a; wd = ~d; memwrite = ~we;
      mack   = (i == ack_cyc);
      mrdata = (i == ack_cyc) ? rdata : $urandom;
      #1;
      chk("req_mreq", mreq, 1);
      chk("req_maddr", maddr, sb[0].addr);
      chk("req_mwe", mwe, sb[0].we);
      chk("req_mwdata", mwdata, sb[0].wdata);
      chk("req_stall", stall, 1);
    end

    @(negedge clk);
    mack = 1'b1; mrdata = 32'hdead_beef;
    #1;
    t = sb.pop_front();
    chk("done_stall", stall, 0);
    chk("done_mreq", mreq, 0);
    chk("done_rd", rd, t.rd);
    irwrite = 1'b0; iord = 1'b0; memwrite = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irwrite = 1'b0; iord = 1'b0; memwrite = 1'b0;
    adr = '0; wd = '0; mack = 1'b0; mrdata = '0;
    #2;
    chk("rst_mreq", mreq, 0);
    chk("rst_mwe", mwe, 0);
    chk("rst_maddr", maddr, 0);
    chk("rst_mwdata", mwdata, 0);
    chk("rst_rd", rd, 0);
    chk("rst_stall", stall, 0);
    chk("rst_terr", timeout_err, 0);
    @(negedge clk);
    reset = 1'b0;

    // fetch read, minimum latency
    access_txn(1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'h2008_0005, 1);
    // store with wait states: rd must keep previous value
    access_txn(1'b0, 1'b1, 32'h0000_0054, 32'h0000_0007, 32'hffff_ffff, 4);
    // back-to-back fetch then load
    access_txn(1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'h8c0a_0000, 2);
    access_txn(1'b0, 1'b0, 32'h0000_0060, 32'h0, 32'h1234_5678, 1);

    // stray acknowledge while idle with no access
    @(negedge clk);
    mack = 1'b1; mrdata = 32'hcafe_f00d;
    #1;
    chk("stray_mreq", mreq, 0);
    chk("stray_stall", stall, 0);
    @(negedge clk);
    mack = 1'b0;
    #1;
    chk("stray_rd", rd, model_rd);
    chk("stray_mreq2", mreq, 0);

    // reset during REQ cycle 2
    @(negedge clk);
    irwrite = 1'b1; adr = 32'h0000_0100;
    #1;
    chk("rq_stall0", stall, 1);
    @(negedge clk);
    #1;
    chk("rq_mreq1", mreq, 1);
    @(negedge clk);
    #1;
    reset = 1'b1; irwrite = 1'b0;
    #1;
    chk("rq_mreq_async", mreq, 0);
    chk("rq_stall_async", stall, 0);
    chk("rq_maddr", maddr, 0);
    chk("rq_rd", rd, 0);
    model_rd = '0;
    @(negedge clk);
    reset = 1'b0;
    access_txn(1'b1, 1'b0, 32'h0000_000c, 32'h0, 32'h0123_4567, 3);

`ifdef MEM_WAIT_BRIDGE_TIMEOUT_EN
    // no acknowledge: four REQ cycles then ERR
    @(negedge clk);
    irwrite = 1'b1; adr = 32'h0000_0200;
    #1;
    for (int unsigned i = 1; i <= 4; i++) begin
      @(negedge clk);
      #1;
      chk("to_req_mreq", mreq, 1);
      chk("to_req_terr", timeout_err, 0);
    end
    @(negedge clk);
    #1;
    chk("to_err_mreq", mreq, 0);
    chk("to_err_terr", timeout_err, 1);
    chk("to_err_stall", stall, 1);
    irwrite = 1'b0; mack = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("to_hold_stall", stall, 1);
      chk("to_hold_terr", timeout_err, 1);
      chk("to_hold_mreq", mreq, 0);
    end
    mack = 1'b0; reset = 1'b1;
    #1;
    chk("to_rst_terr", timeout_err, 0);
    model_rd = '0;
    @(negedge clk);
    reset = 1'b0;
    // acknowledge on the expiring cycle completes normally
    access_txn(1'b0, 1'b0, 32'h0000_0204, 32'h0, 32'h5a5a_a5a5, 4);
    chk("to_race_terr", timeout_err, 0);
`else
    // long wait never times out
    access_txn(1'b0, 1'b0, 32'h0000_0204, 32'h0, 32'h5a5a_a5a5, 12);
    chk("long_terr", timeout_err, 0);
`endif

    @(negedge clk);
    mack = 1'b0;
    #1;
    chk("end_rd", rd, model_rd);
    chk("end_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
